bus_master_if: RTL and testbench
================================

# bus_master_if

Master-side bus interface that sits directly upstream of the bus arbiter, one instance per bus master (CPU instruction port, CPU data port, DMA, debug). Converts a single-access core request into the shared-bus protocol: raises the active-low request to the arbiter, waits for a stable grant, drives one address strobe, waits for slave ready, then returns read data and releases the bus. Also hosts an optional watchdog that aborts accesses to slaves that never respond.

## Interface
- ADDR_W, 30, word-address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 255, ACCESS+WAIT cycles before abort (1..65535; used only with the timeout feature)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- core_as_  in  1  core access strobe, active low, level; held with inputs stable while core_busy=1
- core_rw  in  1  1=read, 0=write
- core_addr  in  ADDR_W  word address
- core_wr_data  in  DATA_W  write data
- core_rd_data  out  DATA_W  read data
- core_busy  out  1  stall to core (combinational)
- core_err  out  1  one-cycle abort pulse (timeout feature only)
- bus_req_  out  1  request to arbiter, active low, registered
- bus_grnt_  in  1  grant from arbiter, active low
- bus_as_  out  1  bus address strobe, active low, registered
- bus_rw  out  1  bus direction, registered
- bus_addr  out  ADDR_W  registered
- bus_wr_data  out  DATA_W  registered
- bus_rd_data  in  DATA_W  slave read data
- bus_rdy_  in  1  slave ready, active low

## Operation
- FSM states IDLE, REQ, ACCESS, WAIT; 2-bit REQ age counter; 16-bit timeout counter.
- IDLE: core_as_=0 → latch core_rw/addr/wr_data into bus_rw/bus_addr/bus_wr_data, bus_req_←0, REQ age←0, go REQ.
- REQ: bus_grnt_ ignored in the first two REQ cycles (arbiter grant lags request by two edges; a lingering grant from a previous ownership is stale). From the third REQ cycle, bus_grnt_=0 → bus_as_←0, go ACCESS. Waiting for grant is unbounded.
- ACCESS: bus_as_ low this cycle only (next state drives it 1). rdy_hit = (ACCESS or WAIT) and bus_rdy_=0. rdy_hit → IDLE, bus_req_←1; else → WAIT.
- WAIT: address/data/rw held; rdy_hit → IDLE, bus_req_←1.
- core_busy = (core_as_=0) and not done, where done = rdy_hit or abort. In IDLE the accepting cycle also reports busy=1.
- core_rd_data = bus_rd_data during a read rdy_hit cycle (pass-through), else registered copy rd_q; rd_q←bus_rd_data on read rdy_hit. Writes leave rd_q unchanged.
- Grant deassertion during ACCESS/WAIT is ignored; transaction completes.
- Back-to-back: core holding core_as_=0 after done starts a new access from IDLE next cycle (full re-arbitration).
- Reset (any state, mid-transaction included): state IDLE, bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0, rd_q=0, counters 0, core_err=0.

## Timing
- Best case (grant already stable, zero-wait slave): accept cycle 0, REQ cycles 1–3, ACCESS cycle 4 with done; core_busy high cycles 0–3, low cycle 4.
- Each slave wait cycle adds one WAIT cycle.
- bus_req_ rises on the edge ending the done cycle; bus_as_ is never low two consecutive cycles.

## Configuration
- BUS_TIMEOUT_EN defined: timeout counter cleared on entry to ACCESS, increments each ACCESS/WAIT cycle without rdy_hit. In the TIMEOUT_CYC-th such cycle without rdy_hit: abort = 1, core_err=1 for that cycle, core_busy=0, core_rd_data=0, rd_q unchanged, bus_req_←1, go IDLE. rdy_hit in the same cycle wins (normal completion, core_err=0).
- Not defined: no counter, core_err tied 0, WAIT indefinite.

## Test plan
- Read, grant held low, bus_rdy_=0 with bus_as_, bus_rd_data=0xDEADBEEF → core_busy cycles 0–3, core_rd_data=0xDEADBEEF in cycle 4, bus_req_=1 in cycle 5.
- Write addr 0x0000_0100, data 0x1234_5678, slave 3 wait cycles → bus_as_ low exactly one cycle, address/data stable through WAIT, done in cycle 7, rd_q unchanged.
- Grant low at request time, deasserted in REQ cycle 2, re-asserted in cycle 6 → no bus_as_ before cycle 7.
- Reset pulsed in WAIT → next cycle IDLE, bus_req_=1, bus_as_=1, core_busy=0 with core_as_=1.
- BUS_TIMEOUT_EN, TIMEOUT_CYC=4, slave silent → core_err one cycle in 4th ACCESS/WAIT cycle, core_rd_data=0, bus_req_ released; repeat with rdy in that cycle → core_err=0, data returned.
- Back-to-back reads with core_as_ held low → second access restarts from REQ; bus_req_ high exactly one cycle between accesses.

Source files
------------

// File: rtl/bus_master_if.sv
// Purpose : master-side shared-bus interface; turns one core access into
//           request / stable grant / single address strobe / slave ready,
//           with an optional no-response watchdog (macro BUS_TIMEOUT_EN).
// Latency : best case 4 cycles accept-to-done (accept, 3 REQ, ACCESS with done);
//           each slave wait cycle adds one WAIT cycle.
// Backpressure: core_busy stalls the core combinationally until the done cycle;
//           waiting for grant is unbounded, and so is waiting for ready unless
//           BUS_TIMEOUT_EN is defined.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   core_as_, core_rw,          core request (strobe active low, level,
//   core_addr, core_wr_data     held stable while core_busy is high)
//   core_rd_data, core_busy,    read data (pass-through on the done cycle),
//   core_err                    stall, one-cycle abort pulse
//   bus_req_, bus_grnt_         arbiter request (registered) / grant, active low
//   bus_as_, bus_rw, bus_addr,  registered bus address phase outputs
//   bus_wr_data
//   bus_rd_data, bus_rdy_       slave read data and ready (active low)
//
// Optional feature macro: BUS_TIMEOUT_EN (watchdog abort after TIMEOUT_CYC
// ACCESS/WAIT cycles without slave ready). Undefined: core_err is tied 0.

module bus_master_if #(
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_as_,
    input  logic              core_rw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_busy,
    output logic              core_err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_WAIT   = 2'd3
    } state_e;

    // The arbiter answers a request two edges later, so any grant seen in
    // the first two REQ cycles belongs to the previous owner.
    localparam logic [1:0] GRANT_AGE = 2'd2;

    state_e            state_q, state_d;
    logic [1:0]        age_q, age_d;
    logic              req_n_q, req_n_d;
    logic              as_n_q, as_n_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_q, rd_d;

    logic              on_bus;
    logic              rdy_hit;
    logic              abort;
    logic              done;

    assign on_bus  = (state_q == ST_ACCESS) || (state_q == ST_WAIT);
    assign rdy_hit = on_bus && !bus_rdy_;
    assign done    = rdy_hit || abort;

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef BUS_TIMEOUT_EN
    // to_q counts ACCESS/WAIT cycles already spent without ready, so the
    // TIMEOUT_CYC-th silent cycle is the one where to_q == TIMEOUT_CYC-1.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] to_q, to_d;

    // Ready in the final cycle wins over the abort.
    assign abort = on_bus && !rdy_hit && (to_q == TO_LAST);

    always_comb begin
        to_d = to_q;
        if ((state_q == ST_REQ) && (state_d == ST_ACCESS)) begin
            to_d = '0;
        end else if (on_bus && !rdy_hit) begin
            to_d = to_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    logic [15:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 16'(TIMEOUT_CYC);
    assign abort              = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM next state and registered bus outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        age_d   = age_q;
        req_n_d = req_n_q;
        as_n_d  = as_n_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!core_as_) begin
                    rw_d    = core_rw;
                    addr_d  = core_addr;
                    wdata_d = core_wr_data;
                    req_n_d = 1'b0;
                    age_d   = 2'd0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (age_q == GRANT_AGE) begin
                    if (!bus_grnt_) begin
                        as_n_d  = 1'b0;
                        state_d = ST_ACCESS;
                    end
                end else begin
                    age_d = age_q + 2'd1;
                end
            end
            ST_ACCESS: begin
                // The strobe is a single-cycle pulse whatever the slave does.
                as_n_d = 1'b1;
                if (done) begin
                    req_n_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done) begin
                    req_n_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rdy_hit && rw_q) begin
            rd_d = bus_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            age_q   <= 2'd0;
            req_n_q <= 1'b1;
            as_n_q  <= 1'b1;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            age_q   <= age_d;
            req_n_q <= req_n_d;
            as_n_q  <= as_n_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_req_    = req_n_q;
    assign bus_as_     = as_n_q;
    assign bus_rw      = rw_q;
    assign bus_addr    = addr_q;
    assign bus_wr_data = wdata_q;

    // The accepting IDLE cycle also stalls; only the done cycle releases.
    assign core_busy = !core_as_ && !done;
    assign core_err  = abort;

    // Read data is forwarded straight from the slave on the done cycle so
    // the core need not wait for rd_q; an aborted access returns zero.
    always_comb begin
        if (rdy_hit && rw_q) begin
            core_rd_data = bus_rd_data;
        end else if (abort) begin
            core_rd_data = '0;
        end else begin
            core_rd_data = rd_q;
        end
    end

endmodule

// File: tb/tb_bus_master_if.sv
`timescale 1ns/1ps
module tb_bus_master_if;
    localparam int AW = 30;
    localparam int DW = 32;
`ifdef BUS_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset        = 1'b1;
    logic          core_as_     = 1'b1;
    logic          core_rw      = 1'b1;
    logic [AW-1:0] core_addr    = '0;
    logic [DW-1:0] core_wr_data = '0;
    logic [DW-1:0] core_rd_data;
    logic          core_busy;
    logic          core_err;
    logic          bus_req_;
    logic          bus_grnt_    = 1'b1;
    logic          bus_as_;
    logic          bus_rw;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wr_data;
    logic [DW-1:0] bus_rd_data  = '0;
    logic          bus_rdy_     = 1'b1;

    bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .core_as_(core_as_), .core_rw(core_rw), .core_addr(core_addr),
        .core_wr_data(core_wr_data), .core_rd_data(core_rd_data),
        .core_busy(core_busy), .core_err(core_err),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_),
        .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change 1ns after the rising edge; everything is observed at
    // the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference model: a transfer is "in flight" from the
    // cycle after acceptance; it is "on the bus" from the first qualified
    // grant; the strobe is the first bus cycle; it ends on ready or abort.
    // ------------------------------------------------------------------
    bit            m_valid = 1'b0;
    bit            m_txn, m_bus;
    int            m_reqc, m_busc;
    logic          m_rw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rdq;
    int            m_dones = 0;

    initial begin
        bit          hit, ab, dn;
        logic [31:0] e_rd;
        forever begin
            @(negedge clk);
            hit = m_bus && !bus_rdy_;
            ab  = 1'b0;
`ifdef BUS_TIMEOUT_EN
            ab  = m_bus && !hit && (m_busc + 1 == TO);
`endif
            dn  = hit || ab;
            e_rd = (hit && m_rw) ? bus_rd_data : (ab ? 32'h0 : m_rdq);
            if (m_valid) begin
                chk1("m_req_n", bus_req_, !m_txn);
                chk1("m_as_n", bus_as_, !(m_bus && (m_busc == 0)));
                chk1("m_rw", bus_rw, m_rw);
                chk("m_addr", 32'(bus_addr), 32'(m_addr));
                chk("m_wdata", bus_wr_data, m_wd);
                chk1("m_busy", core_busy, !core_as_ && !dn);
                chk("m_rd", core_rd_data, e_rd);
                chk1("m_err", core_err, ab);
            end
            if (reset) begin
                m_valid = 1'b1;
                m_txn = 1'b0; m_bus = 1'b0; m_reqc = 0; m_busc = 0;
                m_rw = 1'b1; m_addr = '0; m_wd = '0; m_rdq = '0;
            end else if (m_valid) begin
                if (!m_txn) begin
                    if (!core_as_) begin
                        m_txn = 1'b1; m_bus = 1'b0; m_reqc = 0;
                        m_rw = core_rw; m_addr = core_addr; m_wd = core_wr_data;
                    end
                end else if (!m_bus) begin
                    if (m_reqc >= 2 && !bus_grnt_) begin
                        m_bus = 1'b1;
                        m_busc = 0;
                    end
                    m_reqc++;
                end else if (dn) begin
                    m_txn = 1'b0;
                    m_bus = 1'b0;
                    m_dones++;
                    if (hit && m_rw) m_rdq = bus_rd_data;
                end else begin
                    m_busc++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish required=finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin
        bit free;
        repeat (3) nxt();
        reset = 1'b0;
        mid();
        chk1("rst_req_n", bus_req_, 1'b1);
        chk1("rst_as_n", bus_as_, 1'b1);
        chk1("rst_rw", bus_rw, 1'b1);
        chk("rst_addr", 32'(bus_addr), 32'h0);
        chk("rst_wdata", bus_wr_data, 32'h0);
        chk("rst_rd", core_rd_data, 32'h0);
        chk1("rst_busy", core_busy, 1'b0);
        chk1("rst_err", core_err, 1'b0);
        nxt();

        // Read, grant stable, zero-wait slave.
        bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'hDEADBEEF;
        nxt(); nxt();
        for (int c = 0; c <= 5; c++) begin
            core_as_ = (c <= 4) ? 1'b0 : 1'b1; core_rw = 1'b1; core_addr = 30'h55;
            mid();
            if (c <= 3) chk1("t1_busy", core_busy, 1'b1);
            if (c == 1) chk1("t1_req_low", bus_req_, 1'b0);
            if (c == 3) chk1("t1_as_before", bus_as_, 1'b1);
            if (c == 4) begin
                chk1("t1_busy_done", core_busy, 1'b0);
                chk1("t1_as", bus_as_, 1'b0);
                chk("t1_rd", core_rd_data, 32'hDEADBEEF);
            end
            if (c == 5) chk1("t1_req_rel", bus_req_, 1'b1);
            nxt();
        end

        // Write with three slave wait cycles.
        for (int c = 0; c <= 8; c++) begin
            core_as_ = (c <= 7) ? 1'b0 : 1'b1; core_rw = 1'b0;
            core_addr = 30'h100; core_wr_data = 32'h12345678;
            bus_rdy_ = (c == 7) ? 1'b0 : 1'b1;
            bus_rd_data = $urandom();
            mid();
            if (c >= 1) chk1("t2_as", bus_as_, (c == 4) ? 1'b0 : 1'b1);
            if (c >= 4 && c <= 7) begin
                chk("t2_addr", 32'(bus_addr), 32'h100);
                chk("t2_wdata", bus_wr_data, 32'h12345678);
                chk1("t2_rw", bus_rw, 1'b0);
            end
            if (c == 6) chk1("t2_busy_wait", core_busy, 1'b1);
            if (c == 7) begin
                chk1("t2_busy_done", core_busy, 1'b0);
                chk("t2_rdq_kept", core_rd_data, 32'hDEADBEEF);
            end
            nxt();
        end

        // Grant drops in REQ cycle 2 and returns in cycle 6.
        bus_rdy_ = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            core_as_ = (c <= 7) ? 1'b0 : 1'b1; core_rw = 1'b1; core_addr = 30'h2A;
            bus_grnt_ = (c >= 2 && c <= 5) ? 1'b1 : 1'b0;
            bus_rd_data = 32'h0BADF00D;
            mid();
            if (c >= 1) chk1("t3_as", bus_as_, (c == 7) ? 1'b0 : 1'b1);
            if (c == 7) chk("t3_rd", core_rd_data, 32'h0BADF00D);
            nxt();
        end

        // Reset in WAIT.
        bus_grnt_ = 1'b0; bus_rdy_ = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            core_as_ = (c <= 5) ? 1'b0 : 1'b1; core_rw = 1'b1; core_addr = 30'h3FF;
            reset = (c == 5);
            mid();
            if (c == 5) chk1("t4_wait_as", bus_as_, 1'b1);
            if (c == 6) begin
                chk1("t4_req_n", bus_req_, 1'b1);
                chk1("t4_as_n", bus_as_, 1'b1);
                chk1("t4_busy", core_busy, 1'b0);
                chk("t4_addr", 32'(bus_addr), 32'h0);
                chk("t4_rd", core_rd_data, 32'h0);
            end
            nxt();
        end

`ifdef BUS_TIMEOUT_EN
        // Silent slave, then ready in the final allowed cycle.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c <= 8; c++) begin
                core_as_ = (c <= 7) ? 1'b0 : 1'b1; core_rw = 1'b1; core_addr = 30'h77;
                bus_rdy_ = (r == 1 && c == 7) ? 1'b0 : 1'b1;
                bus_rd_data = 32'hCAFEF00D;
                mid();
                if (c == 6) chk1("t5_err_early", core_err, 1'b0);
                if (c == 7) begin
                    chk1("t5_err", core_err, (r == 0) ? 1'b1 : 1'b0);
                    chk1("t5_busy", core_busy, 1'b0);
                    chk("t5_rd", core_rd_data, (r == 0) ? 32'h0 : 32'hCAFEF00D);
                end
                if (c == 8) begin
                    chk1("t5_err_after", core_err, 1'b0);
                    chk1("t5_req_rel", bus_req_, 1'b1);
                end
                nxt();
            end
        end
`endif

        // Back-to-back reads with the strobe held low.
        bus_grnt_ = 1'b0; bus_rdy_ = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            core_as_ = (c <= 9) ? 1'b0 : 1'b1; core_rw = 1'b1; core_addr = 30'h12;
            bus_rd_data = 32'hA0000000 + 32'(c);
            mid();
            if (c == 4) begin
                chk1("t6_busy1", core_busy, 1'b0);
                chk("t6_rd1", core_rd_data, 32'hA0000004);
            end
            if (c == 5) begin
                chk1("t6_req_gap", bus_req_, 1'b1);
                chk1("t6_busy_acc", core_busy, 1'b1);
            end
            if (c == 6) chk1("t6_req_again", bus_req_, 1'b0);
            if (c == 7 || c == 8) chk1("t6_as_wait", bus_as_, 1'b1);
            if (c == 9) begin
                chk1("t6_as2", bus_as_, 1'b0);
                chk1("t6_busy2", core_busy, 1'b0);
                chk("t6_rd2", core_rd_data, 32'hA0000009);
            end
            if (c == 10) chk1("t6_req_rel", bus_req_, 1'b1);
            nxt();
        end

        // Randomized traffic checked by the model every cycle.
        free = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (free) begin
                core_as_     = ($urandom_range(0, 3) == 0);
                core_rw      = 1'($urandom_range(0, 1));
                core_addr    = AW'($urandom());
                core_wr_data = $urandom();
            end
            bus_grnt_   = ($urandom_range(0, 2) == 0);
            bus_rdy_    = ($urandom_range(0, 9) < 6);
            bus_rd_data = $urandom();
            mid();
            free = !core_busy || reset;
            nxt();
        end
        reset = 1'b0;
        core_as_ = 1'b1;
        nxt();
        chk1("rand_progress", m_dones >= 100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
